// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the external data memory (slave).
// The memory may take any number of cycles to answer a request; mem_ack marks completion.
interface mem_stage_if #(
    parameter int WORD_LEN = 32
);
    logic                mem_req;
    logic                mem_we;
    logic [WORD_LEN-1:0] mem_addr;
    logic [WORD_LEN-1:0] mem_wdata;
    logic                mem_ack;
    logic [WORD_LEN-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: runs a variable-latency req/ack access on the
// data memory, freezes the upstream stages while it waits, and registers the MEM/WB outputs.
// An access that is not acknowledged within TIMEOUT cycles is abandoned and flagged.
module mem_stage #(
    parameter int WORD_LEN     = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int TIMEOUT      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    WB_EN_in,
    input  logic                    Mem_Read_EN_in,
    input  logic                    Mem_Write_EN_in,
    input  logic [WORD_LEN-1:0]     ALU_Result_in,
    input  logic [WORD_LEN-1:0]     Store_Value_in,
    input  logic [REG_ADDR_LEN-1:0] Dest_in,
    mem_stage_if.master             mem,
    output logic                    freeze,
    output logic                    WB_EN,
    output logic                    Mem_Read_EN,
    output logic [WORD_LEN-1:0]     ALU_Result,
    output logic [WORD_LEN-1:0]     Mem_Read_Value,
    output logic [REG_ADDR_LEN-1:0] Dest,
    output logic                    err_timeout
);

    typedef enum logic {IDLE, BUSY} state_t;

    // Last wait count before giving up; wait_cnt is 8 bits since TIMEOUT <= 255.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       access;
    logic       is_read;
    logic       req;
    logic       timeout_now;

    // A combined read+write is treated as a write; the read side is dropped.
    assign access  = Mem_Read_EN_in | Mem_Write_EN_in;
    assign is_read = Mem_Read_EN_in & ~Mem_Write_EN_in;

    assign mem.mem_req   = req;
    assign mem.mem_we    = Mem_Write_EN_in;
    assign mem.mem_addr  = ALU_Result_in;
    assign mem.mem_wdata = Store_Value_in;

    // State register and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Next-state, request and timeout decode; reset forces the bus and freeze quiet.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        req          = 1'b0;
        timeout_now  = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    req = access;
                    if (access && !mem.mem_ack) begin
                        state_nxt    = BUSY;
                        wait_cnt_nxt = 8'd1;
                    end
                end
                BUSY: begin
                    req = 1'b1;
                    if (mem.mem_ack) begin
                        state_nxt    = IDLE;
                        wait_cnt_nxt = 8'd0;
                    end else if (wait_cnt == LAST_WAIT) begin
                        timeout_now  = 1'b1;
                        state_nxt    = IDLE;
                        wait_cnt_nxt = 8'd0;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state_nxt    = IDLE;
                    wait_cnt_nxt = 8'd0;
                end
            endcase
        end
        freeze = req & ~mem.mem_ack & ~timeout_now;
    end

    // MEM/WB register: bubble while frozen, squash write-back on timeout, else capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            WB_EN          <= 1'b0;
            Mem_Read_EN    <= 1'b0;
            ALU_Result     <= '0;
            Mem_Read_Value <= '0;
            Dest           <= '0;
            err_timeout    <= 1'b0;
        end else if (freeze) begin
            WB_EN       <= 1'b0;
            Mem_Read_EN <= 1'b0;
        end else if (timeout_now) begin
            WB_EN          <= 1'b0;
            Mem_Read_EN    <= 1'b0;
            ALU_Result     <= ALU_Result_in;
            Mem_Read_Value <= '0;
            Dest           <= Dest_in;
            err_timeout    <= 1'b1;
        end else begin
            WB_EN          <= WB_EN_in;
            Mem_Read_EN    <= is_read;
            ALU_Result     <= ALU_Result_in;
            Mem_Read_Value <= is_read ? mem.mem_rdata : '0;
            Dest           <= Dest_in;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: the bench plays upstream pipeline and data memory,
// and predicts each instruction's outcome from its type and the memory's ack latency.
module tb_mem_stage;

    localparam int WL = 32;
    localparam int RL = 5;
    localparam int TO = 16;
    localparam int NEVER = 1000;

    logic          clk = 1'b0;
    logic          rst;
    logic          WB_EN_in, Mem_Read_EN_in, Mem_Write_EN_in;
    logic [WL-1:0] ALU_Result_in, Store_Value_in;
    logic [RL-1:0] Dest_in;
    logic          freeze, WB_EN, Mem_Read_EN, err_timeout;
    logic [WL-1:0] ALU_Result, Mem_Read_Value;
    logic [RL-1:0] Dest;

    int total = 0;
    int bad   = 0;
    bit err_exp = 1'b0;

    mem_stage_if #(.WORD_LEN(WL)) mif ();

    mem_stage #(.WORD_LEN(WL), .REG_ADDR_LEN(RL), .TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .WB_EN_in        (WB_EN_in),
        .Mem_Read_EN_in  (Mem_Read_EN_in),
        .Mem_Write_EN_in (Mem_Write_EN_in),
        .ALU_Result_in   (ALU_Result_in),
        .Store_Value_in  (Store_Value_in),
        .Dest_in         (Dest_in),
        .mem             (mif),
        .freeze          (freeze),
        .WB_EN           (WB_EN),
        .Mem_Read_EN     (Mem_Read_EN),
        .ALU_Result      (ALU_Result),
        .Mem_Read_Value  (Mem_Read_Value),
        .Dest            (Dest),
        .err_timeout     (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        WB_EN_in        = 1'b0;
        Mem_Read_EN_in  = 1'b0;
        Mem_Write_EN_in = 1'b0;
        ALU_Result_in   = '0;
        Store_Value_in  = '0;
        Dest_in         = '0;
        mif.mem_ack     = 1'b0;
        mif.mem_rdata   = '0;
    endtask

    // One instruction held at the EXE/MEM boundary until the stage stops freezing.
    // lat = wait cycles before the memory acks (NEVER = no ack at all).
    task automatic run_txn(input bit wb, input bit rd, input bit wr, input logic [WL-1:0] alu,
                           input logic [WL-1:0] st, input logic [RL-1:0] dst, input int lat);
        int            c;
        int            nfrz;
        int            nreq;
        int            exp_frz;
        bit            done;
        bit            acc;
        bit            exp_to;
        bit            exp_rd;
        logic [WL-1:0] rdata;
        acc             = rd | wr;
        WB_EN_in        = wb;
        Mem_Read_EN_in  = rd;
        Mem_Write_EN_in = wr;
        ALU_Result_in   = alu;
        Store_Value_in  = st;
        Dest_in         = dst;
        rdata           = $urandom;
        c = 0; nfrz = 0; nreq = 0; done = 1'b0;
        while (!done && c < 300) begin
            // Without an access, stray acks are thrown in to show they are ignored.
            mif.mem_ack   = acc ? (c == lat) : 1'($urandom_range(0, 1));
            mif.mem_rdata = (acc && c == lat) ? rdata : $urandom;
            @(negedge clk);
            if (mif.mem_req) nreq++;
            if (freeze) nfrz++; else done = 1'b1;
            if (c == 0 && acc) begin
                chk("mem_we", mif.mem_we, wr);
                chk("mem_addr", mif.mem_addr, alu);
                chk("mem_wdata", mif.mem_wdata, st);
            end
            @(posedge clk); #1;
            if (!done) chk("bubble_wb", {Mem_Read_EN, WB_EN}, 0);
            c++;
        end
        mif.mem_ack = 1'b0;
        if (!done) chk("stall_bound", 0, 1);
        exp_frz = !acc ? 0 : (lat < TO - 1 ? lat : TO - 1);
        exp_to  = acc && lat >= TO;
        exp_rd  = rd && !wr && !exp_to;
        err_exp = err_exp | exp_to;
        chk("freeze_cycles", nfrz, exp_frz);
        chk("req_cycles", nreq, acc ? exp_frz + 1 : 0);
        chk("WB_EN", WB_EN, wb && !exp_to);
        chk("Mem_Read_EN", Mem_Read_EN, exp_rd);
        chk("ALU_Result", ALU_Result, alu);
        chk("Dest", Dest, dst);
        chk("Mem_Read_Value", Mem_Read_Value, exp_rd ? rdata : 0);
        chk("err_timeout", err_timeout, err_exp);
    endtask

    initial begin
        int kind;
        int r;
        int lat;
        drive_idle();
        // Reset with a load presented: bus and freeze must stay quiet.
        rst = 1'b1;
        Mem_Read_EN_in = 1'b1;
        @(negedge clk);
        chk("rst_req", mif.mem_req, 0);
        chk("rst_freeze", freeze, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_outs", {WB_EN, Mem_Read_EN, err_timeout, ALU_Result, Mem_Read_Value, Dest}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive_idle();

        // Directed cases.
        run_txn(1, 0, 0, 32'h0000_00A5, 32'h0, 5'd7, 0);
        run_txn(1, 1, 0, 32'h0000_0100, 32'h0, 5'd3, 0);
        run_txn(0, 0, 1, 32'h0000_0200, 32'h0000_1234, 5'd0, 3);
        run_txn(1, 1, 1, 32'h0000_0300, 32'h0000_5678, 5'd9, 1);
        run_txn(1, 1, 0, 32'h0000_0400, 32'h0, 5'd4, TO - 1);
        run_txn(1, 1, 0, 32'h0000_0500, 32'h0, 5'd5, NEVER);
        run_txn(1, 0, 0, 32'h0000_0042, 32'h0, 5'd6, 0);

        // Randomized mix of ALU ops, loads, stores and read+write, with varied latencies.
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 3);
            r    = $urandom_range(0, 9);
            lat  = (r <= 5) ? r : (r == 6) ? TO - 2 : (r == 7) ? TO - 1 : (r == 8) ? TO : NEVER;
            run_txn(1'($urandom_range(0, 1)), kind[0], kind[1], $urandom, $urandom,
                    5'($urandom_range(0, 31)), lat);
        end

        // Reset while a load is waiting: access abandoned, everything cleared.
        Mem_Read_EN_in = 1'b1;
        WB_EN_in       = 1'b1;
        ALU_Result_in  = 32'h0000_0600;
        Dest_in        = 5'd8;
        mif.mem_ack    = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("wait_freeze", freeze, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_req", mif.mem_req, 0);
        chk("midrst_freeze", freeze, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive_idle();
        err_exp = 1'b0;
        @(negedge clk);
        chk("postrst_req", mif.mem_req, 0);
        chk("postrst_outs", {WB_EN, Mem_Read_EN, err_timeout, ALU_Result, Mem_Read_Value, Dest}, 0);
        run_txn(1, 1, 0, 32'h0000_0700, 32'h0, 5'd2, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage of the 5-stage MIPS CPU. It sits between the EXE/MEM pipeline register and the MEM/WB boundary.
- Consumes the EXE/MEM register outputs and runs a req/ack transaction on an external data memory with variable latency.
- Raises freeze to hold IF..EXE/MEM while an access is outstanding, and registers the MEM/WB outputs.
- Includes a timeout counter and a sticky error flag.

Parameters:
- WORD_LEN, 32, data/address width (matches `WORD_LEN).
- REG_ADDR_LEN, 5, destination register index width (matches `REG_FILE_ADDR_LEN).
- TIMEOUT, 16, maximum cycles an access may wait for mem_ack (2..255).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- WB_EN_in  in  1  write-back enable from EXE/MEM.
- Mem_Read_EN_in  in  1  load request from EXE/MEM.
- Mem_Write_EN_in  in  1  store request from EXE/MEM.
- ALU_Result_in  in  WORD_LEN  byte address for memory ops, result otherwise.
- Store_Value_in  in  WORD_LEN  store data.
- Dest_in  in  REG_ADDR_LEN  destination register.
- mem_req  out  1  memory request (combinational).
- mem_we  out  1  1=write, 0=read (combinational).
- mem_addr  out  WORD_LEN  = ALU_Result_in.
- mem_wdata  out  WORD_LEN  = Store_Value_in.
- mem_ack  in  1  transaction complete this cycle.
- mem_rdata  in  WORD_LEN  read data, valid when mem_ack=1.
- freeze  out  1  stall upstream stages and EXE/MEM register (combinational).
- WB_EN  out  1  registered MEM/WB write-back enable.
- Mem_Read_EN  out  1  registered, selects Mem_Read_Value in WB.
- ALU_Result  out  WORD_LEN  registered ALU result.
- Mem_Read_Value  out  WORD_LEN  registered load data.
- Dest  out  REG_ADDR_LEN  registered destination.
- err_timeout  out  1  sticky, set on any timeout.

Behaviour:
- Reset: clk and rst as named; reset is synchronous, active-high.
  - On reset, state=IDLE and wait_cnt=0.
  - WB_EN, Mem_Read_EN and err_timeout reset to 0; ALU_Result, Mem_Read_Value and Dest reset to 0.
  - While rst=1, mem_req=0 and freeze=0.
- Access definitions:
  - access = Mem_Read_EN_in | Mem_Write_EN_in.
  - If both are set, the access is a write: mem_we=1, and the read is ignored (Mem_Read_EN output 0).
- FSM states: IDLE, BUSY.
  - IDLE: mem_req=access. If access & mem_ack, the access completes this cycle (zero-wait) and the state stays IDLE. If access & !mem_ack, go to BUSY with wait_cnt=1.
  - BUSY: mem_req=1. If mem_ack, complete and go to IDLE. Else if wait_cnt==TIMEOUT-1, time out: go to IDLE. Else wait_cnt+1.
- freeze = mem_req & !mem_ack & !timeout_now. Upstream holds all EXE/MEM values stable while freeze=1.
- MEM/WB register, updated each edge:
  - If freeze=1, load a bubble: WB_EN=0, Mem_Read_EN=0, other fields don't-care but held.
  - On normal completion, capture all fields; Mem_Read_Value=mem_rdata if it is a read, else 0.
  - Non-memory instruction: capture in the same cycle (1-cycle latency, freeze=0).
  - On timeout: capture with WB_EN=0 and Mem_Read_Value=0, and set err_timeout=1 until reset.
- Latency: a zero-wait access has 1 cycle and no freeze. An access acked after k wait cycles has k freeze cycles.
- mem_ack arriving with mem_req=0 is ignored.
- Back-to-back accesses: after completion, the next EXE/MEM value appears on the following cycle and is evaluated from IDLE. There is no dead cycle.
- Reset during BUSY: abandon the access, with no completion and no error set.

Test Plan:
- ALU op, WB_EN_in=1, ALU_Result_in=0x0000_00A5, Dest_in=7 -> next edge WB_EN=1, ALU_Result=0xA5, Dest=7; freeze never high.
- Load with addr 0x100, mem_ack same cycle, rdata=0xDEADBEEF -> mem_req 1 cycle, freeze=0; next edge Mem_Read_EN=1, Mem_Read_Value=0xDEADBEEF.
- Store to 0x200, data 0x1234, ack after 3 wait cycles -> mem_req/mem_we high 4 cycles; freeze high 3 cycles; WB_EN bubbles (0) during the wait.
- Read and write both set -> mem_we=1, output Mem_Read_EN=0.
- Load, never acked, TIMEOUT=16 -> freeze high 15 cycles then drops; WB_EN=0, Mem_Read_Value=0, err_timeout=1 and stays 1.
- Load waiting 2 cycles, rst pulsed one cycle -> next cycle state IDLE, mem_req=0, all outputs 0, err_timeout=0.
